fitness_evaluator: RTL

FITNESS_EVALUATOR -- requirements
Module: fitness_evaluator

---
 rtl/fitness_evaluator.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fitness_evaluator.sv
// fitness_evaluator
// Scores a candidate chromosome against a reference truth table by counting
// the bits in which they differ (Hamming distance). The comparison is
// serialised into IndividualWidth/BitsPerCycle steps, LSB slice first. The
// running count saturates at the largest value fitnessError can hold.
//
// Timing for a start accepted at edge 0, with N = IndividualWidth/BitsPerCycle:
//   edges 1..N  : one slice is compared and accumulated at each edge
//   edge  N+1   : fitnessFinish rises for one cycle and fitnessError updates
//   edge  N+2   : the earliest edge at which another start is accepted
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-low reset
//   fitnessStart      request to evaluate; only sampled while idle
//   fitnessIndividual candidate chromosome, latched when a start is accepted
//   target            reference truth table, latched when a start is accepted
//   fitnessFinish     one-cycle completion pulse (registered)
//   fitnessError      mismatch count of the last completed evaluation (registered)
//   busy              high while an evaluation is in progress (registered)
module fitness_evaluator #(
  parameter int ErrorWidth      = 32,
  parameter int IndividualWidth = 32,
  parameter int BitsPerCycle    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fitnessStart,
  input  logic [IndividualWidth-1:0] fitnessIndividual,
  input  logic [IndividualWidth-1:0] target,
  output logic                       fitnessFinish,
  output logic [ErrorWidth-1:0]      fitnessError,
  output logic                       busy
);

  localparam int NumSteps   = IndividualWidth / BitsPerCycle;
  localparam int StepWidth  = (NumSteps > 1) ? $clog2(NumSteps) : 1;
  localparam int CountWidth = $clog2(BitsPerCycle + 1);
  // One guard range above the accumulator so a saturating add never wraps.
  localparam int SumWidth   = ErrorWidth + CountWidth;

  localparam logic [1:0] Idle = 2'd0;
  localparam logic [1:0] Eval = 2'd1;
  localparam logic [1:0] Done = 2'd2;

  localparam logic [StepWidth-1:0]  LastStep = StepWidth'(NumSteps - 1);
  localparam logic [ErrorWidth-1:0] ErrMax   = {ErrorWidth{1'b1}};

  // Number of set bits in one compared slice.
  function automatic logic [CountWidth-1:0] popCount(input logic [BitsPerCycle-1:0] v);
    logic [CountWidth-1:0] cnt;
    cnt = {CountWidth{1'b0}};
    for (int i = 0; i < BitsPerCycle; i++) begin
      cnt = cnt + CountWidth'(v[i]);
    end
    return cnt;
  endfunction

  // Accumulator update that clamps at the all-ones value instead of wrapping.
  function automatic logic [ErrorWidth-1:0] satAdd(input logic [ErrorWidth-1:0] a,
                                                   input logic [CountWidth-1:0] b);
    logic [SumWidth-1:0] sum;
    sum = SumWidth'(a) + SumWidth'(b);
    if (sum > SumWidth'(ErrMax)) begin
      return ErrMax;
    end else begin
      return sum[ErrorWidth-1:0];
    end
  endfunction

  logic [1:0]                 state_r;
  logic [1:0]                 stateNext_s;
  logic [StepWidth-1:0]       stepCount_r;
  logic [ErrorWidth-1:0]      accum_r;
  logic [IndividualWidth-1:0] latchedIndividual_r;
  logic [IndividualWidth-1:0] latchedTarget_r;
  logic                       finish_r;
  logic [ErrorWidth-1:0]      error_r;
  logic                       busy_r;
  logic [IndividualWidth-1:0] diffBits_s;
  logic [BitsPerCycle-1:0]    stepSlice_s;

  // Selects the slice for the current step; an AND-OR mux over constant
  // slice positions keeps every part-select index static.
  always_comb begin
    diffBits_s  = latchedIndividual_r ^ latchedTarget_r;
    stepSlice_s = {BitsPerCycle{1'b0}};
    for (int s = 0; s < NumSteps; s++) begin
      stepSlice_s = stepSlice_s |
                    ({BitsPerCycle{stepCount_r == StepWidth'(s)}} &
                     diffBits_s[s*BitsPerCycle +: BitsPerCycle]);
    end
  end

  // Next-state logic of the IDLE / EVAL / DONE controller.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      Idle: begin
        if (fitnessStart) begin
          stateNext_s = Eval;
        end else begin
          stateNext_s = Idle;
        end
      end
      Eval: begin
        if (stepCount_r == LastStep) begin
          stateNext_s = Done;
        end else begin
          stateNext_s = Eval;
        end
      end
      Done:    stateNext_s = Idle;
      default: stateNext_s = Idle;
    endcase
  end

  // State, datapath and registered outputs. The outputs are registered from
  // the current state, so they trail it by one cycle: busy covers edges
  // 1..N+1 and the finish pulse appears in the cycle after DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r             <= Idle;
      stepCount_r         <= {StepWidth{1'b0}};
      accum_r             <= {ErrorWidth{1'b0}};
      latchedIndividual_r <= {IndividualWidth{1'b0}};
      latchedTarget_r     <= {IndividualWidth{1'b0}};
      finish_r            <= 1'b0;
      error_r             <= {ErrorWidth{1'b0}};
      busy_r              <= 1'b0;
    end else begin
      state_r  <= stateNext_s;
      busy_r   <= (state_r != Idle);
      finish_r <= (state_r == Done);
      case (state_r)
        Idle: begin
          if (fitnessStart) begin
            latchedIndividual_r <= fitnessIndividual;
            latchedTarget_r     <= target;
            accum_r             <= {ErrorWidth{1'b0}};
            stepCount_r         <= {StepWidth{1'b0}};
          end
        end
        Eval: begin
          accum_r     <= satAdd(accum_r, popCount(stepSlice_s));
          stepCount_r <= stepCount_r + StepWidth'(1);
        end
        Done: begin
          // Only the final sum is published; partial sums never reach the port.
          error_r <= accum_r;
        end
        default: begin
          accum_r <= {ErrorWidth{1'b0}};
        end
      endcase
    end
  end

  assign fitnessFinish = finish_r;
  assign fitnessError  = error_r;
  assign busy          = busy_r;

endmodule
